// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    // Arbitration state: default core priority, locked debug burst, forced core slot
    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        BURST     = 2'd1,
        CORE_TURN = 2'd2
    } arb_state_t;

    // Which requester a read in flight belongs to
    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } arb_owner_t;

    // Debug accesses are always full words
    localparam logic [2:0] DBG_FUNCT3 = 3'b010;

    // Owner of a granted access: debug if it holds the grant, core otherwise
    function automatic arb_owner_t owner_of(input logic dbg_gnt);
        if (dbg_gnt) begin
            return OWN_DBG;
        end else begin
            return OWN_CORE;
        end
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Owner-tag delay line: carries {valid,owner} of each granted read alongside the
// memory read latency so the returning data can be steered to its requester.
import dmem_arb_pkg::*;

module arb_tag_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_in,
    input  logic owner_in,
    output logic valid_out,
    output logic owner_out
);

    if (RD_LAT == 0) begin : g_comb
        assign valid_out = valid_in;
        assign owner_out = owner_in;
    end else begin : g_reg
        logic [RD_LAT-1:0] valid_r;
        logic [RD_LAT-1:0] owner_r;

        // Shift tags one stage per cycle; reset drops every read in flight
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_r <= '0;
                owner_r <= '0;
            end else begin
                valid_r[0] <= valid_in;
                owner_r[0] <= owner_in;
                for (int i = 1; i < RD_LAT; i++) begin
                    valid_r[i] <= valid_r[i-1];
                    owner_r[i] <= owner_r[i-1];
                end
            end
        end

        assign valid_out = valid_r[RD_LAT-1];
        assign owner_out = owner_r[RD_LAT-1];
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the core MEM stage and a debug/loader
// port. Core has default priority; debug is protected by a starvation counter, a
// bounded lock-burst mode and unconditional priority while the core is halted.
import dmem_arb_pkg::*;

module dmem_port_arbiter #(
    parameter int DM_ADDRESS   = 9,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  halted,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic                  core_stall,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_rvalid,
    input  logic                  dbg_req,
    input  logic                  dbg_lock,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_gnt,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  dbg_rvalid,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);

    arb_state_t      state_r;
    arb_state_t      state_nxt_s;
    logic [SW-1:0]   starve_cnt_r;
    logic [SW-1:0]   starve_nxt_s;
    logic [BW-1:0]   burst_cnt_r;
    logic [BW-1:0]   burst_nxt_s;
    logic [BW-1:0]   burst_inc_s;
    logic            dbg_wins_s;
    logic            core_gnt_s;
    logic            dbg_gnt_s;
    logic            mem_rd_s;
    logic            mem_wr_s;
    logic [DM_ADDRESS-1:0] mem_addr_s;
    logic [DATA_W-1:0]     mem_wdata_s;
    logic [2:0]            mem_funct3_s;
    logic            tag_valid_s;
    logic            tag_owner_s;

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= NORMAL;
            starve_cnt_r <= '0;
            burst_cnt_r  <= '0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            burst_cnt_r  <= burst_nxt_s;
        end
    end

    // Priority decision and combinational grants for the current cycle
    always_comb begin
        dbg_wins_s = 1'b0;
        if (halted) begin
            dbg_wins_s = 1'b1;
        end else begin
            case (state_r)
                NORMAL:    dbg_wins_s = (starve_cnt_r == SW'(STARVE_LIMIT));
                BURST:     dbg_wins_s = 1'b1;
                CORE_TURN: dbg_wins_s = 1'b0;
                default:   dbg_wins_s = 1'b0;
            endcase
        end
        if (dbg_wins_s) begin
            dbg_gnt_s  = dbg_req;
            core_gnt_s = core_req & ~dbg_req;
        end else begin
            core_gnt_s = core_req;
            dbg_gnt_s  = dbg_req & ~core_req;
        end
    end

    // Next state, saturating burst count and starvation count
    always_comb begin
        state_nxt_s = state_r;
        burst_nxt_s = burst_cnt_r;
        burst_inc_s = (burst_cnt_r == BW'(BURST_MAX)) ? burst_cnt_r : burst_cnt_r + BW'(1);
        if (dbg_req && !dbg_gnt_s) begin
            starve_nxt_s = (starve_cnt_r == SW'(STARVE_LIMIT)) ? starve_cnt_r
                                                               : starve_cnt_r + SW'(1);
        end else begin
            starve_nxt_s = '0;
        end
        case (state_r)
            NORMAL: begin
                if (dbg_gnt_s && dbg_lock && !halted) begin
                    state_nxt_s = BURST;
                    burst_nxt_s = BW'(1);
                end else begin
                    burst_nxt_s = '0;
                end
            end
            BURST: begin
                if (!dbg_lock || !dbg_req) begin
                    state_nxt_s = NORMAL;
                    burst_nxt_s = '0;
                end else if (dbg_gnt_s) begin
                    // Limit applies only while running; it resumes from the current count
                    if (!halted && (burst_inc_s == BW'(BURST_MAX))) begin
                        state_nxt_s = CORE_TURN;
                        burst_nxt_s = '0;
                    end else begin
                        burst_nxt_s = burst_inc_s;
                    end
                end else begin
                    burst_nxt_s = burst_cnt_r;
                end
            end
            CORE_TURN: begin
                state_nxt_s = NORMAL;
                burst_nxt_s = '0;
            end
            default: begin
                state_nxt_s = NORMAL;
                burst_nxt_s = '0;
            end
        endcase
    end

    // Memory-side mux: granted requester drives the port, idle port shows core values
    always_comb begin
        mem_rd_s     = 1'b0;
        mem_wr_s     = 1'b0;
        mem_addr_s   = core_addr;
        mem_wdata_s  = core_wdata;
        mem_funct3_s = core_funct3;
        if (dbg_gnt_s) begin
            mem_rd_s     = ~dbg_we;
            mem_wr_s     = dbg_we;
            mem_addr_s   = dbg_addr;
            mem_wdata_s  = dbg_wdata;
            mem_funct3_s = DBG_FUNCT3;
        end else if (core_gnt_s) begin
            mem_rd_s = ~core_we;
            mem_wr_s = core_we;
        end else begin
            mem_rd_s = 1'b0;
            mem_wr_s = 1'b0;
        end
    end

    arb_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (mem_rd_s),
        .owner_in  (owner_of(dbg_gnt_s)),
        .valid_out (tag_valid_s),
        .owner_out (tag_owner_s)
    );

    assign core_stall  = core_req & ~core_gnt_s;
    assign dbg_gnt     = dbg_gnt_s;
    assign mem_rd      = mem_rd_s;
    assign mem_wr      = mem_wr_s;
    assign mem_addr    = mem_addr_s;
    assign mem_wdata   = mem_wdata_s;
    assign mem_funct3  = mem_funct3_s;
    assign core_rvalid = tag_valid_s & (tag_owner_s == OWN_CORE);
    assign dbg_rvalid  = tag_valid_s & (tag_owner_s == OWN_DBG);
    assign core_rdata  = mem_rdata;
    assign dbg_rdata   = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed cycles check grants and the memory
// port, expected read data is queued per requester and popped by a return monitor.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        halted;
    logic        core_req, core_we;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_funct3;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        core_rvalid;
    logic        dbg_req, dbg_lock, dbg_we;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] core_q[$];
    logic [31:0] dbg_q[$];

    bit [31:0] mem_arr [0:127];
    bit        wr_flag [0:127];

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset), .halted(halted),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3), .core_stall(core_stall),
        .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
        .dbg_rvalid(dbg_rvalid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten words read back as 0xA0000000 + word index
    function automatic logic [31:0] rd_word(input logic [6:0] w);
        if (wr_flag[w]) return mem_arr[w];
        else            return 32'hA000_0000 + {25'd0, w};
    endfunction

    // Data memory model with one cycle of read latency
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rdata <= 32'd0;
        end else begin
            if (mem_wr) begin
                mem_arr[mem_addr[8:2]] <= mem_wdata;
                wr_flag[mem_addr[8:2]] <= 1'b1;
            end
            if (mem_rd) mem_rdata <= rd_word(mem_addr[8:2]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Return monitor: every rvalid must match the oldest expected read of its requester
    always @(negedge clk) begin
        chk("single_rvalid", {31'd0, core_rvalid & dbg_rvalid}, 32'd0);
        if (core_rvalid) begin
            if (core_q.size() == 0) begin
                total++; bad++;
                $display("FAIL core_rvalid_unexpected: got rvalid, expected none");
            end else begin
                chk("core_rdata", core_rdata, core_q.pop_front());
            end
        end
        if (dbg_rvalid) begin
            if (dbg_q.size() == 0) begin
                total++; bad++;
                $display("FAIL dbg_rvalid_unexpected: got rvalid, expected none");
            end else begin
                chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        logic exp_g;
        reset = 1'b1; halted = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = 9'd0; core_wdata = 32'd0;
        core_funct3 = 3'b010;
        dbg_req = 1'b0; dbg_lock = 1'b0; dbg_we = 1'b0; dbg_addr = 9'd0; dbg_wdata = 32'd0;

        // Reset state: everything quiet
        @(negedge clk);
        chk("rst_stall", {31'd0, core_stall}, 32'd0);
        chk("rst_gnt",   {31'd0, dbg_gnt},    32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd},    32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr},    32'd0);
        chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
        chk("rst_rvalid", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // 1: lone core load
        core_req = 1'b1; core_addr = 9'h010;
        @(negedge clk);
        chk("t1_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("t1_stall", {31'd0, core_stall}, 32'd0);
        chk("t1_addr", {23'd0, mem_addr}, 32'h10);
        core_q.push_back(32'hA000_0004);
        next_cycle();
        core_req = 1'b0; core_addr = 9'h1FC;
        @(negedge clk);
        chk("t1_rvalid", {31'd0, core_rvalid}, 32'd1);
        chk("t1_idle_rd", {31'd0, mem_rd}, 32'd0);
        chk("t1_idle_addr", {23'd0, mem_addr}, 32'h1FC);
        next_cycle();

        // 2: starvation forces a debug grant in the fifth cycle
        core_req = 1'b1; core_addr = 9'h010;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h020;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("t2_gnt", {31'd0, dbg_gnt}, {31'd0, (i == 5)});
            chk("t2_stall", {31'd0, core_stall}, {31'd0, (i == 5)});
            if (i == 5) dbg_q.push_back(32'hA000_0008);
            else        core_q.push_back(32'hA000_0004);
            next_cycle();
        end
        dbg_req = 1'b0;
        @(negedge clk);
        chk("t2_core_back", {31'd0, core_stall}, 32'd0);
        core_q.push_back(32'hA000_0004);
        next_cycle();
        core_req = 1'b0;
        next_cycle();

        // 3: locked burst of writes against a held core load
        core_req = 1'b1; core_addr = 9'h010;
        dbg_req = 1'b1; dbg_lock = 1'b1; dbg_we = 1'b1;
        k = 0;
        dbg_addr = 9'h080; dbg_wdata = 32'h1000_0000;
        for (int i = 1; i <= 18; i++) begin
            exp_g = ((i >= 5) && (i <= 12)) || (i >= 17);
            @(negedge clk);
            chk("t3_gnt", {31'd0, dbg_gnt}, {31'd0, exp_g});
            chk("t3_stall", {31'd0, core_stall}, {31'd0, exp_g});
            if (exp_g) begin
                chk("t3_mem_wr", {31'd0, mem_wr}, 32'd1);
                k++;
            end else begin
                core_q.push_back(32'hA000_0004);
            end
            next_cycle();
            dbg_addr = 9'h080 + 9'(4 * k);
            dbg_wdata = 32'h1000_0000 + 32'(k);
        end
        chk("t3_writes", 32'(k), 32'd10);
        dbg_req = 1'b0; dbg_lock = 1'b0; dbg_we = 1'b0; core_req = 1'b0;
        next_cycle();

        // 4: halted gives debug every cycle, no core slot inserted
        halted = 1'b1; dbg_lock = 1'b1;
        core_req = 1'b1; core_addr = 9'h010;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h020;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk("t4_gnt", {31'd0, dbg_gnt}, 32'd1);
            chk("t4_stall", {31'd0, core_stall}, 32'd1);
            dbg_q.push_back(32'hA000_0008);
            next_cycle();
        end
        halted = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0; core_req = 1'b0;
        next_cycle();

        // 5: reset mid-burst with a debug read in flight
        dbg_req = 1'b1; dbg_lock = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h020;
        @(negedge clk);
        chk("t5_gnt_a", {31'd0, dbg_gnt}, 32'd1);
        dbg_q.push_back(32'hA000_0008);
        next_cycle();
        @(negedge clk);
        chk("t5_gnt_b", {31'd0, dbg_gnt}, 32'd1);
        next_cycle();
        reset = 1'b1; dbg_req = 1'b0; dbg_lock = 1'b0;
        @(negedge clk);
        chk("t5_rvalid_dropped", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);
        next_cycle();
        reset = 1'b0;
        core_req = 1'b1; core_addr = 9'h010;
        dbg_req = 1'b1; dbg_lock = 1'b1;
        @(negedge clk);
        chk("t5_normal_core", {31'd0, core_stall}, 32'd0);
        chk("t5_normal_dbg", {31'd0, dbg_gnt}, 32'd0);
        core_q.push_back(32'hA000_0004);
        next_cycle();
        dbg_req = 1'b0; dbg_lock = 1'b0;
        @(negedge clk);
        chk("t5_lone_core", {31'd0, core_stall}, 32'd0);
        chk("t5_lone_rd", {31'd0, mem_rd}, 32'd1);
        core_q.push_back(32'hA000_0004);
        next_cycle();
        core_req = 1'b0;
        next_cycle();

        // 6: debug word write then core load of the same word
        core_funct3 = 3'b100;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h040; dbg_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t6_gnt", {31'd0, dbg_gnt}, 32'd1);
        chk("t6_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("t6_funct3", {29'd0, mem_funct3}, 32'd2);
        chk("t6_wdata", mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        dbg_req = 1'b0; dbg_we = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 9'h040; core_funct3 = 3'b010;
        @(negedge clk);
        chk("t6_core_rd", {31'd0, mem_rd}, 32'd1);
        core_q.push_back(32'hDEAD_BEEF);
        next_cycle();
        core_req = 1'b0;
        repeat (3) next_cycle();

        @(negedge clk);
        chk("core_q_drained", 32'(core_q.size()), 32'd0);
        chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
